// File: rtl/fc_layer_seq.sv
// -----------------------------------------------------------------------------
// fc_layer_seq
//
// Time-multiplexed fully-connected layer on signed 16-bit Q-format data
// (FRAC fractional bits). Computes y[j] = act(bias[j] + sum_i w[j][i]*x[i])
// for N_OUT neurons using N_MAC shared MAC lanes. The neurons are processed in
// G = N_OUT/N_MAC groups; each group takes N_IN MAC cycles plus one ACT cycle,
// so out_valid rises G*(N_IN+1) cycles after the accepting clock edge.
//
// Weights and biases live in internal flops and are written through a simple
// strobe port. Writes are legal only while idle; anything else pulses wt_err.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready is high only in IDLE, and in_valid is ignored elsewhere
// (no queuing). out_valid is high only in OUT; out_vec holds steady until
// out_ready is seen, and out_ready outside OUT has no effect.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   wt_we/wt_addr/wt_data  weight/bias write: addr j*N_IN+i -> w[j][i],
//                          addr N_OUT*N_IN+j -> bias[j]
//   wt_err                 1-cycle pulse for a write outside IDLE or out of range
//   act_sel                0 = piecewise-linear sigmoid, 1 = linear (saturate)
//   in_valid/in_ready      input vector handshake, x[i] = in_vec[16i+:16]
//   out_valid/out_ready    output vector handshake, y[j] = out_vec[16j+:16]
//   busy                   high in MAC/ACT/OUT
//   dbg_state              current FSM state (0 IDLE, 1 MAC, 2 ACT, 3 OUT)
// -----------------------------------------------------------------------------
module fc_layer_seq #(
    parameter int N_IN  = 12,
    parameter int N_OUT = 64,
    parameter int N_MAC = 8,
    parameter int FRAC  = 12
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    wt_we,
    input  logic [$clog2(N_OUT*N_IN+N_OUT)-1:0]     wt_addr,
    input  logic [15:0]                             wt_data,
    output logic                                    wt_err,
    input  logic                                    act_sel,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [16*N_IN-1:0]                      in_vec,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [16*N_OUT-1:0]                     out_vec,
    output logic                                    busy,
    output logic [1:0]                              dbg_state
);

    localparam int G      = N_OUT / N_MAC;
    localparam int N_W    = N_OUT * N_IN;
    localparam int N_ADDR = N_W + N_OUT;
    // 32-bit products summed N_IN times plus a bias: headroom so it never wraps.
    localparam int ACC_W  = 32 + $clog2(N_IN + 1);
    localparam int GW     = (G > 1) ? $clog2(G) : 1;
    localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] ACC_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] ACC_MIN  = -(ACC_W'(32768));

    // Sigmoid breakpoints, slopes' offsets and 1.0 in the same Q format.
    localparam logic [15:0] C_ONE   = 16'(1 << FRAC);
    localparam logic [15:0] C_HALF  = 16'(1 << (FRAC - 1));
    localparam logic [15:0] C_5     = 16'(5 << FRAC);
    localparam logic [15:0] C_2375  = 16'(19 << (FRAC - 3));
    localparam logic [15:0] C_08437 = 16'(27 << (FRAC - 5));
    localparam logic [15:0] C_0625  = 16'(5 << (FRAC - 3));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ACT  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic [IW-1:0]           i_q, i_d;
    logic                    act_sel_q, act_sel_d;
    logic                    wt_err_q, wt_err_d;
    logic signed [15:0]      w_q   [N_W];
    logic signed [15:0]      w_d   [N_W];
    logic signed [15:0]      b_q   [N_OUT];
    logic signed [15:0]      b_d   [N_OUT];
    logic signed [15:0]      x_q   [N_IN];
    logic signed [15:0]      x_d   [N_IN];
    logic signed [ACC_W-1:0] acc_q [N_MAC];
    logic signed [ACC_W-1:0] acc_d [N_MAC];
    logic signed [15:0]      y_q   [N_OUT];
    logic signed [15:0]      y_d   [N_OUT];

    logic signed [31:0]      prod;
    logic signed [15:0]      r_val;

    // Bias aligned to the accumulator's binary point.
    function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [15:0] b);
        logic signed [ACC_W-1:0] e;
        e = ACC_W'(b);
        return e <<< FRAC;
    endfunction

    // Round half up to the output grid, then clamp to the 16-bit range.
    function automatic logic signed [15:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + ACC_HALF) >>> FRAC;
        if (r > ACC_MAX) begin
            return 16'sh7FFF;
        end else if (r < ACC_MIN) begin
            return 16'sh8000;
        end
        return r[15:0];
    endfunction

    // PLAN sigmoid; negative inputs mirror as 1.0 - f(|r|).
    function automatic logic signed [15:0] sigmoid(input logic signed [15:0] r);
        logic [15:0] a;
        logic [15:0] f;
        if (r == 16'sh8000) begin
            a = 16'h7FFF;
        end else if (r < 0) begin
            a = 16'(-r);
        end else begin
            a = r;
        end
        if (a >= C_5) begin
            f = C_ONE;
        end else if (a >= C_2375) begin
            f = (a >> 5) + C_08437;
        end else if (a >= C_ONE) begin
            f = (a >> 3) + C_0625;
        end else begin
            f = (a >> 2) + C_HALF;
        end
        if (r < 0) begin
            f = C_ONE - f;
        end
        return signed'(f);
    endfunction

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        i_d       = i_q;
        act_sel_d = act_sel_q;
        wt_err_d  = 1'b0;
        w_d       = w_q;
        b_d       = b_q;
        x_d       = x_q;
        acc_d     = acc_q;
        y_d       = y_q;
        prod      = '0;
        r_val     = '0;

        // Weight port. Computed before the FSM so an accept in the same cycle
        // loads the freshly written bias for group 0.
        if (wt_we) begin
            if (state_q == S_IDLE && int'(wt_addr) < N_ADDR) begin
                for (int j = 0; j < N_W; j++) begin
                    if (int'(wt_addr) == j) w_d[j] = wt_data;
                end
                for (int j = 0; j < N_OUT; j++) begin
                    if (int'(wt_addr) == N_W + j) b_d[j] = wt_data;
                end
            end else begin
                wt_err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_MAC;
                    g_d       = '0;
                    i_d       = '0;
                    act_sel_d = act_sel;
                    for (int i = 0; i < N_IN; i++) begin
                        x_d[i] = in_vec[16*i +: 16];
                    end
                    for (int k = 0; k < N_MAC; k++) begin
                        acc_d[k] = bias_acc(b_d[k]);
                    end
                end
            end

            S_MAC: begin
                for (int k = 0; k < N_MAC; k++) begin
                    prod     = w_q[(int'(g_q) * N_MAC + k) * N_IN + int'(i_q)] * x_q[i_q];
                    acc_d[k] = acc_q[k] + ACC_W'(prod);
                end
                if (int'(i_q) == N_IN - 1) begin
                    i_d     = '0;
                    state_d = S_ACT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end

            S_ACT: begin
                for (int k = 0; k < N_MAC; k++) begin
                    r_val = round_sat(acc_q[k]);
                    y_d[int'(g_q) * N_MAC + k] = act_sel_q ? r_val : sigmoid(r_val);
                end
                if (int'(g_q) == G - 1) begin
                    state_d = S_OUT;
                end else begin
                    g_d     = g_q + 1'b1;
                    state_d = S_MAC;
                    for (int k = 0; k < N_MAC; k++) begin
                        acc_d[k] = bias_acc(b_q[(int'(g_q) + 1) * N_MAC + k]);
                    end
                end
            end

            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            i_q       <= '0;
            act_sel_q <= 1'b0;
            wt_err_q  <= 1'b0;
            w_q       <= '{default: '0};
            b_q       <= '{default: '0};
            x_q       <= '{default: '0};
            acc_q     <= '{default: '0};
            y_q       <= '{default: '0};
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            i_q       <= i_d;
            act_sel_q <= act_sel_d;
            wt_err_q  <= wt_err_d;
            w_q       <= w_d;
            b_q       <= b_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign wt_err    = wt_err_q;
    assign dbg_state = state_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_vec[16*j +: 16] = y_q[j];
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq in the N_IN=2, N_OUT=2, N_MAC=1, FRAC=12
// configuration. Address map: 0..3 = w[j][i] at j*2+i, 4 = bias0, 5 = bias1.
// Expected vectors are hand-computed and written as {y1, y0}.
module tb_fc_layer_seq;

    logic        clk;
    logic        rst_n;
    logic        wt_we;
    logic [2:0]  wt_addr;
    logic [15:0] wt_data;
    logic        wt_err;
    logic        act_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vec;
    logic        busy;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int lat;

    fc_layer_seq #(
        .N_IN (2),
        .N_OUT(2),
        .N_MAC(1),
        .FRAC (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wt_we    (wt_we),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .wt_err   (wt_err),
        .act_sel  (act_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic write_wt(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        wt_we   = 1'b1;
        wt_addr = addr;
        wt_data = data;
        @(negedge clk);
        wt_we   = 1'b0;
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic start_vec(input logic [15:0] x0, input logic [15:0] x1, input logic act);
        @(negedge clk);
        in_vec   = {x1, x0};
        act_sel  = act;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                             input logic act, input logic [31:0] exp);
        int n;
        start_vec(x0, x1, act);
        wait_out(n);
        check({tag, "_lat"}, n, 6);
        check(tag, out_vec, exp);
        consume();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_wt_err"},    {31'd0, wt_err},    32'd0);
        check({tag, "_out_vec"},   out_vec,            32'd0);
    endtask

    initial begin
        // reset block
        rst_n     = 1'b0;
        wt_we     = 1'b0;
        wt_addr   = '0;
        wt_data   = '0;
        act_sel   = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // unit weights, zero biases
        for (int a = 0; a < 4; a++) write_wt(3'(a), 16'h1000);
        check("wt_ok_no_err", {31'd0, wt_err}, 32'd0);
        write_wt(3'd4, 16'h0000);
        write_wt(3'd5, 16'h0000);

        // 2.0 -> sigmoid 0.875 / linear 2.0
        run_check("sig_ones", 16'h1000, 16'h1000, 1'b0, 32'h0E00_0E00);
        run_check("lin_ones", 16'h1000, 16'h1000, 1'b1, 32'h2000_2000);

        // bias1 = -1.0
        write_wt(3'd5, 16'hF000);
        run_check("lin_bias", 16'h1000, 16'h1000, 1'b1, 32'h1000_2000);
        run_check("sig_bias", 16'h1000, 16'h1000, 1'b0, 32'h0C00_0E00);
        // r0 = -2.0 -> 0.125 ; r1 = -3.0 -> 1 - (3/32 + 0.84375) = 0.0625
        run_check("sig_neg", 16'hF000, 16'hF000, 1'b0, 32'h0100_0200);
        // y0 = 1 lsb ; y1 = -1.0 + 1 lsb
        run_check("lin_lsb", 16'h0001, 16'h0000, 1'b1, 32'hF001_0001);

        // w00 = 0.5 : acc0 = +/- half an lsb, rounds half up
        write_wt(3'd0, 16'h0800);
        run_check("rnd_half_pos", 16'h0001, 16'h0000, 1'b1, 32'hF001_0001);
        run_check("rnd_half_neg", 16'hFFFF, 16'h0000, 1'b1, 32'hEFFF_0000);

        // saturation with max weights
        for (int a = 0; a < 4; a++) write_wt(3'(a), 16'h7FFF);
        write_wt(3'd5, 16'h0000);
        run_check("lin_sat_pos", 16'h7FFF, 16'h7FFF, 1'b1, 32'h7FFF_7FFF);
        run_check("sig_sat_pos", 16'h7FFF, 16'h7FFF, 1'b0, 32'h1000_1000);
        run_check("lin_sat_neg", 16'h8000, 16'h8000, 1'b1, 32'h8000_8000);
        run_check("sig_sat_neg", 16'h8000, 16'h8000, 1'b0, 32'h0000_0000);

        // hold OUT with out_ready low; input pulses must be ignored
        start_vec(16'h7FFF, 16'h7FFF, 1'b1);
        wait_out(lat);
        check("hold_lat", lat, 6);
        for (int c = 0; c < 10; c++) begin
            check("hold_out_vec",   out_vec,               32'h7FFF_7FFF);
            check("hold_in_ready",  {31'd0, in_ready},     32'd0);
            check("hold_out_valid", {31'd0, out_valid},    32'd1);
            in_valid = (c % 2 == 0);
            in_vec   = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
            act_sel  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume();
        check("hold_exit_in_ready", {31'd0, in_ready}, 32'd1);
        check("hold_exit_busy",     {31'd0, busy},     32'd0);
        check("hold_exit_out_vec",  out_vec,           32'h7FFF_7FFF);

        // write during MAC: error pulse, weight untouched
        start_vec(16'h0010, 16'h0000, 1'b1);
        wt_we   = 1'b1;
        wt_addr = 3'd0;
        wt_data = 16'h0000;
        @(negedge clk);
        wt_we = 1'b0;
        check("err_mac_pulse", {31'd0, wt_err}, 32'd1);
        @(negedge clk);
        check("err_mac_clear", {31'd0, wt_err}, 32'd0);
        wait_out(lat);
        check("err_mac_valid", {31'd0, out_valid}, 32'd1);
        check("err_mac_y", out_vec, 32'h0080_0080);
        consume();
        run_check("err_mac_rerun", 16'h0010, 16'h0000, 1'b1, 32'h0080_0080);

        // out-of-range write while idle
        write_wt(3'd6, 16'h0000);
        check("err_range_pulse", {31'd0, wt_err}, 32'd1);
        @(negedge clk);
        check("err_range_clear", {31'd0, wt_err}, 32'd0);
        run_check("err_range_rerun", 16'h0010, 16'h0000, 1'b1, 32'h0080_0080);

        // reset in the middle of MAC
        start_vec(16'h0010, 16'h0000, 1'b1);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst_n = 1'b1;
        // cleared weights and biases: linear 0, sigmoid(0) = 0.5
        run_check("rst_lin_zero", 16'h7FFF, 16'h7FFF, 1'b1, 32'h0000_0000);
        run_check("rst_sig_half", 16'h7FFF, 16'h7FFF, 1'b0, 32'h0800_0800);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
